// File: rtl/lsu_v_pkg.sv
// Shared definitions for the load/store unit: opcodes, funct3 codes, error
// codes, FSM states and helpers for access legality and store lane formatting.
// Contents: opcode/funct3 constants, lsu_state_t, lsu_check, store_strb, store_wdata.
package lsu_v_pkg;

  // Opcodes decoded by the unit
  localparam logic [6:0] I_LOAD = 7'b0000011;
  localparam logic [6:0] S_TYPE = 7'b0100011;
  localparam logic [6:0] R_TYPE = 7'b0110011;
  localparam logic [6:0] I_IMM  = 7'b0010011;

  // Load funct3
  localparam logic [2:0] F3_LB  = 3'd0;
  localparam logic [2:0] F3_LH  = 3'd1;
  localparam logic [2:0] F3_LW  = 3'd2;
  localparam logic [2:0] F3_LBU = 3'd4;
  localparam logic [2:0] F3_LHU = 3'd5;

  // Store funct3
  localparam logic [2:0] F3_SB = 3'd0;
  localparam logic [2:0] F3_SH = 3'd1;
  localparam logic [2:0] F3_SW = 3'd2;

  // Error codes reported alongside wb_valid
  localparam logic [1:0] LSU_ERR_NONE     = 2'b00;
  localparam logic [1:0] LSU_ERR_MISALIGN = 2'b01;
  localparam logic [1:0] LSU_ERR_ILLEGAL  = 2'b10;
  localparam logic [1:0] LSU_ERR_TIMEOUT  = 2'b11;

  typedef enum logic [0:0] {
    LSU_IDLE   = 1'b0,
    LSU_ACCESS = 1'b1
  } lsu_state_t;

  // Legality of a memory access; an illegal funct3 is reported in preference
  // to misalignment because the width of an illegal access is meaningless.
  function automatic logic [1:0] lsu_check(input logic is_load, input logic [2:0] f3,
                                           input logic [1:0] lo);
    logic       legal;
    logic [1:0] err;
    if (is_load)
      legal = (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
              (f3 == F3_LBU) || (f3 == F3_LHU);
    else
      legal = (f3 == F3_SB) || (f3 == F3_SH) || (f3 == F3_SW);
    err = LSU_ERR_NONE;
    if (!legal)
      err = LSU_ERR_ILLEGAL;
    else if (f3[1:0] == 2'd1 && lo[0])     // LH, LHU, SH
      err = LSU_ERR_MISALIGN;
    else if (f3[1:0] == 2'd2 && lo != 2'b00) // LW, SW
      err = LSU_ERR_MISALIGN;
    return err;
  endfunction

  function automatic logic [3:0] store_strb(input logic [2:0] f3, input logic [1:0] lo);
    logic [3:0] s;
    case (f3)
      F3_SB:   s = 4'b0001 << lo;
      F3_SH:   s = lo[1] ? 4'b1100 : 4'b0011;
      default: s = 4'b1111;
    endcase
    return s;
  endfunction

  // Data is replicated across lanes so the strobe alone selects the target bytes
  function automatic logic [31:0] store_wdata(input logic [2:0] f3, input logic [31:0] d);
    logic [31:0] w;
    case (f3)
      F3_SB:   w = {4{d[7:0]}};
      F3_SH:   w = {2{d[15:0]}};
      default: w = d;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/lsu_v_load_ext.sv
// Load data extraction: selects the byte/half-word lane of the read word and
// sign- or zero-extends it according to funct3. Purely combinational.
// Ports: funct3, addr_lo (addr[1:0]), mem_rdata in; ext_data out.
module load_ext_v
  import lsu_v_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] mem_rdata,
  output logic [31:0] ext_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = mem_rdata[8*addr_lo +: 8];
    half_sel = addr_lo[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    ext_data = mem_rdata;
    case (funct3)
      F3_LB:   ext_data = {{24{byte_sel[7]}}, byte_sel};
      F3_LH:   ext_data = {{16{half_sel[15]}}, half_sel};
      F3_LBU:  ext_data = {24'd0, byte_sel};
      F3_LHU:  ext_data = {16'd0, half_sel};
      default: ext_data = mem_rdata;
    endcase
  end

endmodule

// File: rtl/lsu_v.sv
// Load/store unit: pass-through of ALU results, and a request/acknowledge
// memory transaction for loads and stores with lane handling, sign extension,
// misalignment/illegal-funct3 detection and a bus timeout.
// Ports: valid_in/ready_out + op/funct3/addr/s_data/rd upstream; mem_* to data
// memory; wb_valid/wb_we/wb_rd/wb_data/err_code towards writeback.
module lsu_v
  import lsu_v_pkg::*;
#(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid_in,
  output logic        ready_out,
  input  logic [6:0]  op,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] s_data,
  input  logic [4:0]  rd,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        wb_valid,
  output logic        wb_we,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic [1:0]  err_code
);

  // Last counter value before abort: the request is held TIMEOUT_CYC cycles
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYC - 1);

  lsu_state_t  state;
  logic [7:0]  cnt;
  logic [2:0]  r_f3;
  logic [1:0]  r_lo;
  logic [4:0]  r_rd;

  logic        is_load, is_store, is_alu;
  logic [1:0]  acc_err;
  logic [31:0] ext_data;

  assign ready_out = (state == LSU_IDLE);
  assign is_load   = (op == I_LOAD);
  assign is_store  = (op == S_TYPE);
  assign is_alu    = (op == R_TYPE) || (op == I_IMM);
  assign acc_err   = lsu_check(is_load, funct3, addr[1:0]);

  load_ext_v u_load_ext (
    .funct3   (r_f3),
    .addr_lo  (r_lo),
    .mem_rdata(mem_rdata),
    .ext_data (ext_data)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= LSU_IDLE;
      cnt       <= '0;
      r_f3      <= '0;
      r_lo      <= '0;
      r_rd      <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wstrb <= '0;
      wb_valid  <= 1'b0;
      wb_we     <= 1'b0;
      wb_rd     <= '0;
      wb_data   <= '0;
      err_code  <= LSU_ERR_NONE;
    end else begin
      // Writeback is a single-cycle pulse; fields read as zero otherwise
      wb_valid <= 1'b0;
      wb_we    <= 1'b0;
      wb_rd    <= '0;
      wb_data  <= '0;
      err_code <= LSU_ERR_NONE;

      case (state)
        LSU_IDLE: begin
          if (valid_in) begin
            if (is_load || is_store) begin
              if (acc_err != LSU_ERR_NONE) begin
                wb_valid <= 1'b1;
                wb_rd    <= rd;
                err_code <= acc_err;
              end else begin
                state     <= LSU_ACCESS;
                cnt       <= '0;
                r_f3      <= funct3;
                r_lo      <= addr[1:0];
                r_rd      <= rd;
                mem_req   <= 1'b1;
                mem_we    <= is_store;
                mem_addr  <= {addr[31:2], 2'b00};
                mem_wstrb <= is_store ? store_strb(funct3, addr[1:0]) : 4'b0000;
                mem_wdata <= is_store ? store_wdata(funct3, s_data) : 32'd0;
              end
            end else begin
              wb_valid <= 1'b1;
              wb_rd    <= rd;
              wb_data  <= addr;
              wb_we    <= is_alu && (rd != 5'd0);
            end
          end
        end

        LSU_ACCESS: begin
          cnt <= cnt + 8'd1;
          // Ack is checked first so it wins over a coincident timeout
          if (mem_ack || cnt == TO_LAST) begin
            state     <= LSU_IDLE;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wstrb <= '0;
            wb_valid  <= 1'b1;
            wb_rd     <= r_rd;
            if (!mem_ack) begin
              err_code <= LSU_ERR_TIMEOUT;
            end else if (!mem_we) begin
              wb_we   <= (r_rd != 5'd0);
              wb_data <= ext_data;
            end
          end
        end

        default: state <= LSU_IDLE;
      endcase
    end
  end

endmodule
